// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin two-port sequencer for the shared SRAM
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_drive,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  // The strobe counter counts down from WAIT_CYCLES-1 to 0 inclusive.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                gnt_ldr_q, gnt_ldr_d;   // 1 = loader owns the current access
  logic                last_ldr_q, last_ldr_d; // 1 = loader was granted most recently
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic                pick_ldr;

  // Loader wins when it is alone, or on a tie when the CPU was served last.
  assign pick_ldr = ldr_req && (!cpu_req || !last_ldr_q);

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      gnt_ldr_q   <= 1'b0;
      last_ldr_q  <= 1'b1;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      gnt_ldr_q   <= gnt_ldr_d;
      last_ldr_q  <= last_ldr_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  // Next-state logic: grant and latch in IDLE, time the strobe, capture read data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    gnt_ldr_d   = gnt_ldr_q;
    last_ldr_d  = last_ldr_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || ldr_req) begin
          gnt_ldr_d  = pick_ldr;
          last_ldr_d = pick_ldr;
          addr_d     = pick_ldr ? ldr_addr  : cpu_addr;
          wdata_d    = pick_ldr ? ldr_wdata : cpu_wdata;
          we_d       = pick_ldr ? ldr_we    : cpu_we;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_INIT;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_ldr_q) ldr_rdata_d = sram_rdata;
            else           cpu_rdata_d = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin and handshake outputs decoded purely from state and latched registers.
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce_n  = !((state_q == SETUP) || (state_q == ACCESS));
  assign sram_oe_n  = !((state_q == ACCESS) && !we_q);
  assign sram_we_n  = !((state_q == ACCESS) && we_q);
  // Drive stays on through DONE so write data is held after WE rises.
  assign sram_drive = we_q && (state_q != IDLE);
  assign cpu_ack    = (state_q == DONE) && !gnt_ldr_q;
  assign ldr_ack    = (state_q == DONE) && gnt_ldr_q;
  assign busy       = (state_q != IDLE);
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int viol = 0;

  // Instance A: default WAIT_CYCLES=2
  logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
  logic [15:0] cpu_rdata, ldr_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        cpu_ack, ldr_ack, sram_ce_n, sram_oe_n, sram_we_n, sram_drive, busy;

  // Instance B: WAIT_CYCLES=5
  logic        cpu_req_b = 0, cpu_we_b = 0, ldr_req_b = 0, ldr_we_b = 0;
  logic [15:0] cpu_addr_b = 0, cpu_wdata_b = 0, ldr_addr_b = 0, ldr_wdata_b = 0;
  logic [15:0] cpu_rdata_b, ldr_rdata_b, sram_addr_b, sram_wdata_b, sram_rdata_b;
  logic        cpu_ack_b, ldr_ack_b, sram_ce_n_b, sram_oe_n_b, sram_we_n_b, sram_drive_b, busy_b;

  sram_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_drive(sram_drive), .busy(busy)
  );

  sram_arbiter #(.WAIT_CYCLES(5)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b),
    .ldr_req(ldr_req_b), .ldr_we(ldr_we_b), .ldr_addr(ldr_addr_b), .ldr_wdata(ldr_wdata_b),
    .ldr_rdata(ldr_rdata_b), .ldr_ack(ldr_ack_b),
    .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b),
    .sram_ce_n(sram_ce_n_b), .sram_oe_n(sram_oe_n_b), .sram_we_n(sram_we_n_b),
    .sram_drive(sram_drive_b), .busy(busy_b)
  );

  // SRAM model for A: 0x3000 is preloaded with 0x1234, other words come from writes.
  logic [15:0] mem [0:65535];
  assign sram_rdata = (!sram_ce_n && !sram_oe_n)
                      ? ((sram_addr == 16'h3000) ? 16'h1234 : mem[sram_addr]) : 16'h0000;
  always @(posedge Clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_wdata;
  end

  // SRAM model for B: constant read pattern.
  assign sram_rdata_b = (!sram_ce_n_b && !sram_oe_n_b) ? 16'h5A5A : 16'h0000;

  // Strobe-legality monitor for both instances.
  logic bad_a, bad_b;
  assign bad_a = (!sram_we_n && !sram_oe_n) || ((!sram_we_n || !sram_oe_n) && sram_ce_n);
  assign bad_b = (!sram_we_n_b && !sram_oe_n_b) || ((!sram_we_n_b || !sram_oe_n_b) && sram_ce_n_b);
  always @(negedge Clk) begin
    viol <= viol + int'(bad_a) + int'(bad_b);
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    tick;
    tick;
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_drive, busy, cpu_ack, ldr_ack} !== 7'b1110000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b",
               {sram_ce_n, sram_oe_n, sram_we_n, sram_drive, busy, cpu_ack, ldr_ack}, 7'b1110000);
    end
    checks++;
    if ({sram_addr, sram_wdata} !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr_wdata got=%h exp=%h", {sram_addr, sram_wdata}, 32'h0);
    end
    checks++;
    if ({cpu_rdata, ldr_rdata} !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=%h", {cpu_rdata, ldr_rdata}, 32'h0);
    end
    checks++;
    if ({sram_ce_n_b, sram_oe_n_b, sram_we_n_b, busy_b, cpu_ack_b} !== 5'b11100) begin
      failures++;
      $display("FAIL reset_b_ctrl got=%b exp=%b",
               {sram_ce_n_b, sram_oe_n_b, sram_we_n_b, busy_b, cpu_ack_b}, 5'b11100);
    end
  endtask

  task automatic test_cpu_read;
    logic [15:0] oe_v, ce_v, we_v, ack_v, lack_v, rd;
    oe_v = 0; ce_v = 0; we_v = 0; ack_v = 0; lack_v = 0; rd = 16'hxxxx;
    cpu_we = 0; cpu_addr = 16'h3000; cpu_req = 1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      oe_v[c] = !sram_oe_n; ce_v[c] = !sram_ce_n; we_v[c] = !sram_we_n;
      ack_v[c] = cpu_ack; lack_v[c] = ldr_ack;
      if (cpu_ack) begin rd = cpu_rdata; cpu_req = 0; end
    end
    checks++;
    if (oe_v !== 16'h000C) begin failures++; $display("FAIL cpu_read_oe got=%h exp=%h", oe_v, 16'h000C); end
    checks++;
    if (ce_v !== 16'h000E) begin failures++; $display("FAIL cpu_read_ce got=%h exp=%h", ce_v, 16'h000E); end
    checks++;
    if ({we_v, lack_v} !== 32'h0) begin failures++; $display("FAIL cpu_read_we_lack got=%h exp=0", {we_v, lack_v}); end
    checks++;
    if (ack_v !== 16'h0010) begin failures++; $display("FAIL cpu_read_ack got=%h exp=%h", ack_v, 16'h0010); end
    checks++;
    if (rd !== 16'h1234) begin failures++; $display("FAIL cpu_read_data got=%h exp=%h", rd, 16'h1234); end
    checks++;
    if (ldr_rdata !== 16'h0000) begin failures++; $display("FAIL cpu_read_ldr_rdata got=%h exp=0000", ldr_rdata); end
  endtask

  task automatic test_ldr_write;
    logic [15:0] we_v, drv_v, ack_v, cack_v;
    we_v = 0; drv_v = 0; ack_v = 0; cack_v = 0;
    ldr_we = 1; ldr_addr = 16'h0200; ldr_wdata = 16'hBEEF; ldr_req = 1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      we_v[c] = !sram_we_n; drv_v[c] = sram_drive; ack_v[c] = ldr_ack; cack_v[c] = cpu_ack;
      if (ldr_ack) ldr_req = 0;
    end
    checks++;
    if (we_v !== 16'h000C) begin failures++; $display("FAIL ldr_write_we got=%h exp=%h", we_v, 16'h000C); end
    checks++;
    if (drv_v !== 16'h001E) begin failures++; $display("FAIL ldr_write_drive got=%h exp=%h", drv_v, 16'h001E); end
    checks++;
    if ({ack_v, cack_v} !== 32'h0010_0000) begin
      failures++; $display("FAIL ldr_write_acks got=%h exp=%h", {ack_v, cack_v}, 32'h0010_0000);
    end
    checks++;
    if (mem[16'h0200] !== 16'hBEEF) begin failures++; $display("FAIL ldr_write_mem got=%h exp=BEEF", mem[16'h0200]); end
    checks++;
    if ({cpu_rdata, ldr_rdata} !== 32'h1234_0000) begin
      failures++; $display("FAIL ldr_write_rdata got=%h exp=12340000", {cpu_rdata, ldr_rdata});
    end
  endtask

  task automatic test_tie;
    logic [31:0] cack_v, lack_v;
    cack_v = 0; lack_v = 0;
    do_reset;
    cpu_we = 0; cpu_addr = 16'h3000;
    ldr_we = 0; ldr_addr = 16'h0200;
    cpu_req = 1; ldr_req = 1;
    for (int c = 1; c <= 17; c++) begin
      tick;
      cack_v[c] = cpu_ack; lack_v[c] = ldr_ack;
      if (c == 14) begin cpu_req = 0; ldr_req = 0; end
    end
    checks++;
    if (cack_v !== 32'h0000_4010) begin failures++; $display("FAIL tie_cpu_acks got=%h exp=%h", cack_v, 32'h4010); end
    checks++;
    if (lack_v !== 32'h0000_0200) begin failures++; $display("FAIL tie_ldr_acks got=%h exp=%h", lack_v, 32'h0200); end
    checks++;
    if ({cpu_rdata, ldr_rdata} !== 32'h1234_BEEF) begin
      failures++; $display("FAIL tie_rdata got=%h exp=1234BEEF", {cpu_rdata, ldr_rdata});
    end
  endtask

  task automatic test_wait_busy;
    logic [15:0] oe_v, we_v, cack_v, lack_v, busy_v;
    oe_v = 0; we_v = 0; cack_v = 0; lack_v = 0; busy_v = 0;
    cpu_we = 0; cpu_addr = 16'h3000; cpu_req = 1;
    for (int c = 1; c <= 11; c++) begin
      tick;
      oe_v[c] = !sram_oe_n; we_v[c] = !sram_we_n; busy_v[c] = busy;
      cack_v[c] = cpu_ack; lack_v[c] = ldr_ack;
      if (cpu_ack) cpu_req = 0;
      if (ldr_ack) ldr_req = 0;
      if (c == 2) begin
        ldr_we = 1; ldr_addr = 16'h0300; ldr_wdata = 16'h5555; ldr_req = 1;
      end
    end
    checks++;
    if ({oe_v, we_v} !== {16'h000C, 16'h0180}) begin
      failures++; $display("FAIL busy_strobes got=%h exp=%h", {oe_v, we_v}, {16'h000C, 16'h0180});
    end
    checks++;
    if ({cack_v, lack_v} !== {16'h0010, 16'h0200}) begin
      failures++; $display("FAIL busy_acks got=%h exp=%h", {cack_v, lack_v}, {16'h0010, 16'h0200});
    end
    checks++;
    if (busy_v !== 16'h03DE) begin failures++; $display("FAIL busy_flag got=%h exp=%h", busy_v, 16'h03DE); end
    checks++;
    if (mem[16'h0300] !== 16'h5555) begin failures++; $display("FAIL busy_mem got=%h exp=5555", mem[16'h0300]); end
    checks++;
    if (ldr_rdata !== 16'hBEEF) begin failures++; $display("FAIL busy_ldr_rdata got=%h exp=BEEF", ldr_rdata); end
  endtask

  task automatic test_reset_mid;
    int acks;
    acks = 0;
    do_reset;
    cpu_we = 0; cpu_addr = 16'h3000; cpu_req = 1;
    tick;
    tick;
    checks++;
    if (sram_oe_n !== 1'b0) begin failures++; $display("FAIL rmid_in_access got=%b exp=0", sram_oe_n); end
    Reset = 1;
    tick;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_drive, busy, cpu_ack} !== 6'b111000) begin
      failures++; $display("FAIL rmid_outputs got=%b exp=%b",
                           {sram_ce_n, sram_oe_n, sram_we_n, sram_drive, busy, cpu_ack}, 6'b111000);
    end
    Reset = 0; cpu_req = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      acks += int'(cpu_ack) + int'(ldr_ack);
    end
    checks++;
    if (acks !== 0) begin failures++; $display("FAIL rmid_no_ack got=%0d exp=0", acks); end
    checks++;
    if (cpu_rdata !== 16'h0000) begin failures++; $display("FAIL rmid_rdata got=%h exp=0000", cpu_rdata); end
  endtask

  task automatic test_wait5;
    logic [15:0] oe_v, ce_v, ack_v;
    oe_v = 0; ce_v = 0; ack_v = 0;
    cpu_we_b = 0; cpu_addr_b = 16'h1000; cpu_req_b = 1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      oe_v[c] = !sram_oe_n_b; ce_v[c] = !sram_ce_n_b; ack_v[c] = cpu_ack_b;
      if (cpu_ack_b) cpu_req_b = 0;
    end
    checks++;
    if (oe_v !== 16'h007C) begin failures++; $display("FAIL w5_oe got=%h exp=%h", oe_v, 16'h007C); end
    checks++;
    if (ce_v !== 16'h007E) begin failures++; $display("FAIL w5_ce got=%h exp=%h", ce_v, 16'h007E); end
    checks++;
    if (ack_v !== 16'h0080) begin failures++; $display("FAIL w5_ack got=%h exp=%h", ack_v, 16'h0080); end
    checks++;
    if (cpu_rdata_b !== 16'h5A5A) begin failures++; $display("FAIL w5_rdata got=%h exp=5A5A", cpu_rdata_b); end
  endtask

  task automatic test_no_overlap;
    checks++;
    if (viol !== 0) begin failures++; $display("FAIL strobe_legality got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_ldr_write;
    test_tie;
    test_wait_busy;
    test_reset_mid;
    test_wait5;
    test_no_overlap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequences every access to the shared 16-bit SRAM and shares it between two requesters: the SLC-3 CPU datapath (MAR/MDR path driven by the control unit) and the program loader/debug port. It converts single-cycle request handshakes into correctly timed SRAM chip-enable/output-enable/write-enable sequences with a fixed, parameterised strobe width. It also arbitrates round-robin when both requesters ask in the same cycle. It sits between the datapath/loader and the top-level SRAM pins/tristate buffer.

## Interface
- WAIT_CYCLES, 2, cycles the OE/WE strobe is held active (legal range 1–15)
- ADDR_W, 16, address width
- DATA_W, 16, data width

- Clk  in  1  clock
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req
- cpu_rdata  out  DATA_W  last read data returned to CPU
- cpu_ack  out  1  one-cycle completion pulse to CPU
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack  same as the cpu_* ports, for the loader
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  data to the SRAM tristate buffer
- sram_rdata  in  DATA_W  data from the SRAM pins
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low
- sram_drive  out  1  1 = top level drives sram_wdata onto the pins
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered or decoded from state and registers only; there are no combinational paths from inputs to outputs.
- IDLE: if any request is high, grant and latch the selected requester's addr/we/wdata into internal registers, then go to SETUP. Otherwise stay in IDLE.
- Arbitration:
  - Only one requester high: grant it.
  - Both high: grant the requester not served last.
  - last_grant updates on each grant. Its reset value is LDR, so the CPU wins the first tie.
- SETUP (1 cycle): sram_ce_n=0, sram_addr=latched addr, strobes inactive, sram_drive=we. Go to ACCESS with counter=WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles): sram_ce_n=0, and sram_oe_n=0 for a read or sram_we_n=0 for a write. Decrement the counter. When counter=0, go to DONE; a read captures sram_rdata into the granted requester's rdata register on that same edge.
- DONE (1 cycle): ack=1 to the granted requester only, strobes inactive, sram_ce_n=1, sram_drive held at we for data hold. Go to IDLE.
- The non-granted requester's rdata is never modified. rdata holds until that requester's next read completes. Writes leave rdata unchanged.
- A request arriving while busy waits. It is sampled only in IDLE.
- Requesters drop req on the edge that ends the DONE cycle. A req still high in IDLE is treated as a new access.
- WAIT_CYCLES outside 1–15 is unsupported. The counter is 4 bits.

## Timing
- Reset values: state IDLE, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_drive=0, sram_addr=0, sram_wdata=0, cpu_ack=0, ldr_ack=0, cpu_rdata=0, ldr_rdata=0, busy=0, last_grant=LDR.
- Request sampled in IDLE at cycle 0 gives: SETUP at cycle 1, ACCESS at cycles 2..WAIT_CYCLES+1, ack at cycle WAIT_CYCLES+2. With the default this is ack at cycle 4.
- Read data is valid in the ack cycle and remains valid afterwards.
- Back-to-back throughput: one access every WAIT_CYCLES+3 cycles (IDLE is always revisited).
- With both requesters continuously requesting, grants alternate strictly.
- Reset asserted in any state: on the next edge all outputs return to their reset values. An access in progress is abandoned with no ack and no rdata update.
- sram_we_n and sram_oe_n are never low in the same cycle. Neither strobe is ever low while sram_ce_n=1.

## Test plan
- CPU read at 0x3000, SRAM model returns 0x1234, WAIT_CYCLES=2 -> sram_oe_n low in cycles 2–3, cpu_ack pulse in cycle 4, cpu_rdata=0x1234, ldr_rdata unchanged at 0.
- Loader write 0xBEEF to 0x0200 -> sram_we_n low exactly 2 cycles, sram_drive high from SETUP through DONE, the model holds 0xBEEF at 0x0200, ldr_ack pulses once.
- cpu_req and ldr_req both raised in the same cycle after reset, both held -> the CPU is served first, then the loader, then the CPU. Acks are 5 cycles apart.
- Loader requests during a CPU access (ACCESS state) -> the loader waits and is granted in the IDLE that follows the CPU's DONE. No strobe overlap occurs.
- Reset asserted in the first ACCESS cycle of a read -> the next cycle shows all strobes high, busy=0, no ack, and cpu_rdata still holds its previous value of 0.
- WAIT_CYCLES=5 read -> the OE low-width is 5 cycles and the ack arrives in cycle 7.
